pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit.sv | 133 +++++++++++++
 tb/tb_pc_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// pc_unit: program counter sequencer with BOOT/RUN/HALT control, redirect priority and fetch counter.
// Latency: pc updates one cycle after the controlling inputs; flush, pc_valid and halted are combinational from state.
// Backpressure: stall holds pc unless a redirect is present; halt_req parks the block until resume.
// Optional feature macro PC_WRAP_TRAP_EN: trap and halt instead of wrapping from pc=127.
module pc_unit #(
  parameter logic [6:0] RESET_PC = 7'd0,
  parameter int         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [6:0]       branch_target,
  input  logic             jump,
  input  logic [6:0]       jump_target,
  input  logic             halt_req,
  input  logic             resume,
  output logic [6:0]       pc,
  output logic             pc_valid,
  output logic             flush,
  output logic             halted,
  output logic             wrap_trap,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [6:0] pc_nxt;
  logic       redirect;
  logic       cnt_inc;

  assign redirect = branch_taken | jump;

  // Status outputs decode directly from the state register.
  assign pc_valid = (state == RUN);
  assign halted   = (state == HALT);
  assign flush    = (state == RUN) & redirect;
  // A fetch advances whenever RUN is not held back; a redirect still counts under stall.
  assign cnt_inc  = (state == RUN) & (~stall | redirect);

`ifdef PC_WRAP_TRAP_EN
  logic trap_hit;
  logic trap_q;
`endif

  // Next-state and next-pc selection; branch beats jump beats stall beats increment.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
`ifdef PC_WRAP_TRAP_EN
    trap_hit  = 1'b0;
`endif
    case (state)
      BOOT: begin
        state_nxt = RUN;
      end
      RUN: begin
        if (branch_taken) begin
          pc_nxt = branch_target;
        end else if (jump) begin
          pc_nxt = jump_target;
        end else if (stall) begin
          pc_nxt = pc;
        end else begin
`ifdef PC_WRAP_TRAP_EN
          // Stop at the top of the address space rather than silently wrapping.
          if (pc == 7'd127) begin
            pc_nxt    = pc;
            state_nxt = HALT;
            trap_hit  = 1'b1;
          end else begin
            pc_nxt = pc + 7'd1;
          end
`else
          pc_nxt = pc + 7'd1;
`endif
        end
        if (halt_req) begin
          state_nxt = HALT;
        end
      end
      HALT: begin
        // resume wins over halt_req; pc is held either way.
        if (resume) begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = BOOT;
      end
    endcase
  end

  // State and pc registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= BOOT;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  // Saturating count of advancing fetches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_count <= '0;
    end else if (cnt_inc && (fetch_count != {CNT_W{1'b1}})) begin
      fetch_count <= fetch_count + 1'b1;
    end
  end

`ifdef PC_WRAP_TRAP_EN
  // Sticky overflow flag; only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trap_q <= 1'b0;
    end else if (trap_hit) begin
      trap_q <= 1'b1;
    end
  end
  assign wrap_trap = trap_q;
`else
  assign wrap_trap = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: reset, redirect priority, halt/resume, overflow,
// asynchronous reset and counter saturation (second instance with a 4-bit counter).
`timescale 1ns/1ps
module tb_pc_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [6:0]  branch_target;
  logic        jump;
  logic [6:0]  jump_target;
  logic        halt_req;
  logic        resume;

  logic [6:0]  pc, pc4;
  logic        pc_valid, pc_valid4;
  logic        flush, flush4;
  logic        halted, halted4;
  logic        wrap_trap, wrap_trap4;
  logic [15:0] fetch_count;
  logic [3:0]  fetch_count4;

  int n_vec = 0;
  int n_err = 0;

  pc_unit dut (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .halt_req(halt_req), .resume(resume),
    .pc(pc), .pc_valid(pc_valid), .flush(flush), .halted(halted),
    .wrap_trap(wrap_trap), .fetch_count(fetch_count)
  );

  pc_unit #(.RESET_PC(7'd0), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .halt_req(halt_req), .resume(resume),
    .pc(pc4), .pc_valid(pc_valid4), .flush(flush4), .halted(halted4),
    .wrap_trap(wrap_trap4), .fetch_count(fetch_count4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; branch_taken = 0; branch_target = 0;
    jump = 0; jump_target = 0; halt_req = 0; resume = 0;
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    #12;
    // Held in reset
    check("rst_pc", pc, 0);
    check("rst_valid", pc_valid, 0);
    check("rst_halted", halted, 0);
    check("rst_flush", flush, 0);
    check("rst_cnt", fetch_count, 0);
    check("rst_trap", wrap_trap, 0);
    reset = 1'b1;
    #1;
    check("boot_valid", pc_valid, 0);
    check("boot_pc", pc, 0);

    // BOOT -> RUN, then three advances
    step();
    check("run0_pc", pc, 0);
    check("run0_valid", pc_valid, 1);
    check("run0_cnt", fetch_count, 0);
    step(); check("run1_pc", pc, 1);
    step(); check("run2_pc", pc, 2);
    step(); check("run3_pc", pc, 3);
    check("run3_cnt", fetch_count, 3);
    check("run3_valid", pc_valid, 1);
    step(); step();
    check("run5_pc", pc, 5);

    // Stall with branch and jump: branch wins, flush is combinational
    stall = 1; branch_taken = 1; branch_target = 7'd40; jump = 1; jump_target = 7'd9;
    #1;
    check("redir_flush", flush, 1);
    step();
    check("redir_pc", pc, 40);
    check("redir_cnt", fetch_count, 6);
    idle_inputs();
    // Plain stall holds pc and count
    stall = 1;
    #1;
    check("stall_flush", flush, 0);
    step();
    check("stall_pc", pc, 40);
    check("stall_cnt", fetch_count, 6);
    stall = 0;

    // Jump alone
    jump = 1; jump_target = 7'd12;
    step();
    check("jump_pc", pc, 12);
    // Halt together with jump: redirect applied first
    jump = 1; jump_target = 7'd20; halt_req = 1;
    step();
    check("halt_pc", pc, 20);
    check("halt_halted", halted, 1);
    check("halt_valid", pc_valid, 0);
    check("halt_cnt", fetch_count, 8);
    // Redirects and stall ignored in HALT
    idle_inputs();
    branch_taken = 1; branch_target = 7'd99; jump = 1; jump_target = 7'd33;
    #1;
    check("halt_flush", flush, 0);
    step(); step(); step();
    check("halt3_pc", pc, 20);
    check("halt3_cnt", fetch_count, 8);
    check("halt3_halted", halted, 1);
    // resume beats simultaneous halt_req
    idle_inputs();
    resume = 1; halt_req = 1;
    step();
    check("resume_halted", halted, 0);
    check("resume_pc", pc, 20);
    check("resume_valid", pc_valid, 1);
    idle_inputs();
    step();
    check("resume_adv_pc", pc, 21);
    check("resume_adv_cnt", fetch_count, 9);
    // resume in RUN has no effect
    resume = 1;
    step();
    check("resume_run_pc", pc, 22);
    check("resume_run_halted", halted, 0);
    resume = 0;

    // Overflow at pc=127
    jump = 1; jump_target = 7'd125;
    step();
    jump = 0;
    step(); step();
    check("ovf_127", pc, 127);
    step();
`ifdef PC_WRAP_TRAP_EN
    check("ovf_pc", pc, 127);
    check("ovf_halted", halted, 1);
    check("ovf_trap", wrap_trap, 1);
    resume = 1;
    step();
    resume = 0;
    check("ovf_resume_valid", pc_valid, 1);
    check("ovf_trap_sticky", wrap_trap, 1);
`else
    check("ovf_pc", pc, 0);
    check("ovf_halted", halted, 0);
    check("ovf_trap", wrap_trap, 0);
`endif

    // Park in HALT at pc=50, then reset between edges
    jump = 1; jump_target = 7'd50; halt_req = 1;
    step();
    idle_inputs();
    check("pre_rst_pc", pc, 50);
    check("pre_rst_halted", halted, 1);
    branch_taken = 1; branch_target = 7'd7;
    #2;
    reset = 1'b0;
    #1;
    check("arst_pc", pc, 0);
    check("arst_halted", halted, 0);
    check("arst_valid", pc_valid, 0);
    check("arst_flush", flush, 0);
    check("arst_cnt", fetch_count, 0);
    check("arst_trap", wrap_trap, 0);
    idle_inputs();
    #2;
    reset = 1'b1;

    // Saturation: BOOT edge then 20 unstalled advances
    step();
    check("sat_boot_cnt4", fetch_count4, 0);
    repeat (20) step();
    check("sat_cnt4", fetch_count4, 15);
    check("sat_cnt16", fetch_count, 20);
    check("sat_pc", pc, 20);
    step(); step();
    check("sat_hold_cnt4", fetch_count4, 15);
    check("sat_hold_cnt16", fetch_count, 22);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
